// File: rtl/rf_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rf_arb_pkg
//  Description : Shared state encoding and default widths for the register-
//                file read arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package rf_arb_pkg;

    // Default register-file geometry: 32 registers of 32 bits.
    localparam int RF_ARB_AW = 5;
    localparam int RF_ARB_DW = 32;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage : rf_arb_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin selector. Searches the request
//                vector starting at ptr_i and ascending modulo NREQ; returns
//                a one-hot grant and the binary index of the winner.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IDW-1:0]  winner_o,
    output logic            any_o
);

    // One extra bit so ptr + offset can exceed NREQ-1 before wrapping.
    localparam int SW = IDW + 1;

    logic [SW-1:0]  w_sum;
    logic [IDW-1:0] w_idx;
    logic           w_found;

    // Walk the requesters in priority order; the first active one wins.
    always_comb begin
        grant_o  = '0;
        winner_o = '0;
        w_found  = 1'b0;
        w_sum    = '0;
        w_idx    = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_sum = {1'b0, ptr_i} + SW'(k);
            if (w_sum >= SW'(NREQ)) begin
                w_sum = w_sum - SW'(NREQ);
            end
            w_idx = w_sum[IDW-1:0];
            if (!w_found && req_i[w_idx]) begin
                w_found        = 1'b1;
                grant_o[w_idx] = 1'b1;
                winner_o       = w_idx;
            end
        end
        any_o = w_found;
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/rf_read_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rf_read_arbiter
//  Description : Shares one register-file read port among NREQ requesters.
//                Round-robin grant in IDLE (or on response hand-off), drives
//                the read-mux select for one cycle in READ, then holds the
//                captured data in RESP until the consumer accepts it.
//                Optional feature macro RF_ARB_ZERO_REG_EN: a read of
//                register 0 bypasses READ and returns zero directly.
//  Revision    : 1.0 - initial release
// ============================================================================
module rf_read_arbiter
    import rf_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int DW   = RF_ARB_DW,
    parameter int AW   = RF_ARB_AW,
    parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NREQ-1:0]    req_valid_i,
    input  logic [NREQ*AW-1:0] req_addr_i,
    output logic [NREQ-1:0]    req_ready_o,
    output logic [AW-1:0]      s_o,
    input  logic [DW-1:0]      y_i,
    output logic               rsp_valid_o,
    output logic [IDW-1:0]     rsp_id_o,
    output logic [DW-1:0]      rsp_data_o,
    input  logic               rsp_ready_i
);

    state_t          state_q, state_d;
    logic [IDW-1:0]  ptr_q,   ptr_d;
    logic [AW-1:0]   s_q,     s_d;
    logic [IDW-1:0]  id_q,    id_d;
    logic [DW-1:0]   data_q,  data_d;

    logic [NREQ-1:0] w_grant;
    logic [IDW-1:0]  w_winner;
    logic            w_any;
    logic [AW-1:0]   w_addr;
    logic            w_do_grant;
    logic [NREQ-1:0] w_req_ready;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_arbiter (
        .req_i    (req_valid_i),
        .ptr_i    (ptr_q),
        .grant_o  (w_grant),
        .winner_o (w_winner),
        .any_o    (w_any)
    );

    // Pick out the address belonging to the one-hot winner.
    always_comb begin
        w_addr = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_addr = req_addr_i[i*AW +: AW];
            end
        end
    end

    // Next-state, grant and datapath-load decisions.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        s_d         = s_q;
        id_d        = id_q;
        data_d      = data_q;
        w_do_grant  = 1'b0;
        w_req_ready = '0;

        case (state_q)
            IDLE: begin
                w_do_grant = w_any;
            end
            READ: begin
                data_d  = y_i;
                state_d = RESP;
            end
            RESP: begin
                // The response is released only on handshake; a pending
                // request is granted in that same cycle to keep 1 read / 2 cycles.
                if (rsp_ready_i) begin
                    w_do_grant = w_any;
                    if (!w_any) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (w_do_grant) begin
            w_req_ready = w_grant;
            id_d        = w_winner;
            ptr_d       = (w_winner == IDW'(NREQ - 1)) ? '0 : w_winner + 1'b1;
`ifdef RF_ARB_ZERO_REG_EN
            // Register 0 reads as zero: skip the mux cycle, leave S alone.
            if (w_addr == '0) begin
                data_d  = '0;
                state_d = RESP;
            end else begin
                s_d     = w_addr;
                state_d = READ;
            end
`else
            s_d     = w_addr;
            state_d = READ;
`endif
        end
    end

    // State and datapath registers; reset discards any in-flight read.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            s_q     <= '0;
            id_q    <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            s_q     <= s_d;
            id_q    <= id_d;
            data_q  <= data_d;
        end
    end

    // Grant is combinational, so mask it while reset is held.
    assign req_ready_o = w_req_ready & {NREQ{~rst_i}};
    assign s_o         = s_q;
    assign rsp_valid_o = (state_q == RESP);
    assign rsp_id_o    = id_q;
    assign rsp_data_o  = data_q;

endmodule : rf_read_arbiter
`default_nettype wire

// File: tb/tb_rf_read_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rf_read_arbiter
//  Description : Directed bench for rf_read_arbiter. The read mux is modelled
//                as Y = S * 0x11. Expected grants and responses are queued by
//                the stimulus and consumed by an independent monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rf_read_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 32;
    localparam int AW   = 5;
    localparam int IDW  = 2;

    typedef struct {
        int          id;
        logic [31:0] data;
    } rsp_t;

    logic               clk;
    logic               rst;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ-1:0]    req_ready;
    logic [AW-1:0]      s;
    logic [DW-1:0]      y;
    logic               rsp_valid;
    logic [IDW-1:0]     rsp_id;
    logic [DW-1:0]      rsp_data;
    logic               rsp_ready;

    int n_checks = 0;
    int n_fail   = 0;

    logic [NREQ-1:0] exp_grant[$];
    rsp_t            exp_rsp[$];

    rf_read_arbiter #(
        .NREQ (NREQ),
        .DW   (DW),
        .AW   (AW)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_addr_i  (req_addr),
        .req_ready_o (req_ready),
        .s_o         (s),
        .y_i         (y),
        .rsp_valid_o (rsp_valid),
        .rsp_id_o    (rsp_id),
        .rsp_data_o  (rsp_data),
        .rsp_ready_i (rsp_ready)
    );

    // Register-file mux model.
    assign y = {27'd0, s} * 32'h11;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input int idx, input logic [AW-1:0] a);
        req_addr[idx*AW +: AW] = a;
    endtask

    task automatic push(input logic [NREQ-1:0] g, input int id, input logic [31:0] d);
        rsp_t r;
        exp_grant.push_back(g);
        r.id   = id;
        r.data = d;
        exp_rsp.push_back(r);
    endtask

    // Monitor: every grant and every accepted response is matched in order.
    always @(negedge clk) begin
        if (!rst) begin
            if (req_ready != '0) begin
                if (exp_grant.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_grant: got 0x%0h, expected none", req_ready);
                end else begin
                    check("grant", 32'(req_ready), 32'(exp_grant.pop_front()));
                end
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_rsp.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_rsp: got id %0d data 0x%0h, expected none", rsp_id, rsp_data);
                end else begin
                    rsp_t r;
                    r = exp_rsp.pop_front();
                    check("rsp_id",   32'(rsp_id), 32'(r.id));
                    check("rsp_data", rsp_data,    r.data);
                end
            end
        end
    end

    initial begin
        // ---------------- reset state ----------------
        rst       = 1'b1;
        req_valid = '1;
        req_addr  = '0;
        rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_id",    32'(rsp_id),    32'd0);
        check("rst_rsp_data",  rsp_data,       32'd0);
        check("rst_s",         32'(s),         32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        req_valid = '0;
        next_cycle();
        rst = 1'b0;
        next_cycle();

        // ---------------- single request, requester 2, addr 7 ----------------
        req_valid = 4'b0100;
        set_addr(2, 5'd7);
        push(4'b0100, 2, 32'h77);
        @(negedge clk);
        check("single_c0_rsp_valid", 32'(rsp_valid), 32'd0);
        next_cycle();
        req_valid = '0;
        @(negedge clk);
        check("single_c1_rsp_valid", 32'(rsp_valid), 32'd0);
        check("single_c1_s",         32'(s),         32'd7);
        next_cycle();
        @(negedge clk);
        check("single_c2_rsp_valid", 32'(rsp_valid), 32'd1);
        next_cycle();

        // ---------------- pointer wrap: grant 3, then 0 beats 3 ----------------
        req_valid = 4'b1000;
        set_addr(3, 5'd3);
        push(4'b1000, 3, 32'h33);
        next_cycle();
        req_valid = '0;
        next_cycle();
        next_cycle();
        req_valid = 4'b1001;
        set_addr(0, 5'd1);
        push(4'b0001, 0, 32'h11);
        @(negedge clk);
        check("wrap_winner", 32'(req_ready), 32'b0001);
        next_cycle();
        req_valid = '0;
        next_cycle();
        next_cycle();

        // ---------------- reset during READ ----------------
        req_valid = 4'b0010;
        set_addr(1, 5'd9);
        exp_grant.push_back(4'b0010);
        next_cycle();
        req_valid = '0;
        #2;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("midrst_s",         32'(s),         32'd0);
        check("midrst_rsp_data",  rsp_data,       32'd0);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("postrst_c1_rsp_valid", 32'(rsp_valid), 32'd0);
        next_cycle();
        @(negedge clk);
        check("postrst_c2_rsp_valid", 32'(rsp_valid), 32'd0);
        next_cycle();

        // ---------------- all four valid, round-robin from PTR=0 ----------------
        set_addr(0, 5'd4);
        set_addr(1, 5'd5);
        set_addr(2, 5'd6);
        set_addr(3, 5'd8);
        for (int c = 0; c <= 10; c++) begin
            req_valid = (c <= 8) ? 4'hF : 4'h0;
            if (c % 2 == 0 && c <= 8) begin
                case ((c / 2) % 4)
                    0: push(4'b0001, 0, 32'h44);
                    1: push(4'b0010, 1, 32'h55);
                    2: push(4'b0100, 2, 32'h66);
                    default: push(4'b1000, 3, 32'h88);
                endcase
            end
            @(negedge clk);
            check("rr_rsp_valid", 32'(rsp_valid), (c >= 2 && c % 2 == 0) ? 32'd1 : 32'd0);
            next_cycle();
        end

        // ---------------- backpressure ----------------
        rsp_ready = 1'b0;
        req_valid = 4'b0010;
        set_addr(1, 5'd10);
        push(4'b0010, 1, 32'hAA);
        next_cycle();
        req_valid = 4'b0100;
        set_addr(2, 5'd12);
        @(negedge clk);
        check("bp_read_req_ready", 32'(req_ready), 32'd0);
        next_cycle();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            check("bp_rsp_id",    32'(rsp_id),    32'd1);
            check("bp_rsp_data",  rsp_data,       32'hAA);
            check("bp_req_ready", 32'(req_ready), 32'd0);
            next_cycle();
        end
        rsp_ready = 1'b1;
        push(4'b0100, 2, 32'hCC);
        @(negedge clk);
        check("bp_release_grant", 32'(req_ready), 32'b0100);
        next_cycle();
        req_valid = '0;
        next_cycle();
        next_cycle();

        // ---------------- register 0 read ----------------
        req_valid = 4'b0001;
        set_addr(0, 5'd0);
        push(4'b0001, 0, 32'h0);
        next_cycle();
        req_valid = '0;
        @(negedge clk);
`ifdef RF_ARB_ZERO_REG_EN
        check("zero_c1_rsp_valid", 32'(rsp_valid), 32'd1);
        check("zero_c1_s",         32'(s),         32'd12);
`else
        check("zero_c1_rsp_valid", 32'(rsp_valid), 32'd0);
        check("zero_c1_s",         32'(s),         32'd0);
`endif
        next_cycle();
        @(negedge clk);
`ifdef RF_ARB_ZERO_REG_EN
        check("zero_c2_rsp_valid", 32'(rsp_valid), 32'd0);
`else
        check("zero_c2_rsp_valid", 32'(rsp_valid), 32'd1);
`endif
        next_cycle();

        // ---------------- drain ----------------
        repeat (4) next_cycle();
        @(negedge clk);
        check("final_rsp_valid",   32'(rsp_valid),        32'd0);
        check("pending_grants",    32'(exp_grant.size()), 32'd0);
        check("pending_responses", 32'(exp_rsp.size()),   32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_rf_read_arbiter
`default_nettype wire

// File: doc/rf_read_arbiter.md
RF_READ_ARBITER -- requirements
Module: rf_read_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4: number of requesters sharing the register-file read port.
REQ-002 SHALL have parameter DW, default 32: data width of the register-file read path.
REQ-003 SHALL have parameter AW, default 5: register select width, addressing 32 registers.
REQ-004 Clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Rst  input  1  reset; asynchronous, active-high.
REQ-006 REQ_VALID  input  NREQ  per-requester read request.
REQ-007 REQ_ADDR  input  NREQ*AW  per-requester register number; requester i occupies bits [i*AW +: AW].
REQ-008 REQ_READY  output  NREQ  one-hot grant; the request is accepted when VALID and READY are both high.
REQ-009 S  output  AW  select driven to the 32-way register read mux.
REQ-010 Y  input  DW  mux output; valid in the same cycle as S.
REQ-011 RSP_VALID  output  1  response available.
REQ-012 RSP_ID  output  clog2(NREQ)  index of the requester that owns the response.
REQ-013 RSP_DATA  output  DW  read data.
REQ-014 RSP_READY  input  1  consumer accepts the response.

Function
REQ-015 SHALL implement FSM states IDLE, READ, RESP.
REQ-016 IDLE: if any REQ_VALID is high, SHALL assert REQ_READY for exactly one winner chosen round-robin, latch its address and id, and go to READ; otherwise stay in IDLE.
REQ-017 Round-robin: priority SHALL start at index PTR and ascend modulo NREQ; after a grant, PTR SHALL become winner+1 and wrap from NREQ-1 to 0.
REQ-018 READ: S SHALL equal the latched address; at the clock edge, Y SHALL be captured into RSP_DATA and the FSM SHALL go to RESP.
REQ-019 RESP: RSP_VALID=1, and RSP_ID and RSP_DATA SHALL be held stable until RSP_READY is sampled high.
REQ-020 RESP with RSP_READY=1 and any REQ_VALID high: SHALL grant the next winner in the same cycle and go directly to READ (back-to-back, sustained throughput of 1 read per 2 cycles).
REQ-021 RESP with RSP_READY=1 and no request pending: SHALL go to IDLE.
REQ-022 REQ_READY SHALL be all zero in READ, and in RESP while RSP_READY=0.
REQ-023 Grant latency from REQ_VALID rising in IDLE to RSP_VALID SHALL be 2 cycles.
REQ-024 S SHALL hold its last latched value outside READ and SHALL not be driven X.
REQ-025 A requester dropping REQ_VALID before it is granted SHALL simply lose its turn; PTR SHALL be unchanged.

Reset
REQ-026 On Rst high, asynchronously: state=IDLE, PTR=0, S=0, RSP_VALID=0, RSP_ID=0, RSP_DATA=0, REQ_READY=0.
REQ-027 Rst asserted mid-transaction SHALL discard the in-flight request with no response issued.

Configuration
REQ-028 Macro RF_ARB_ZERO_REG_EN defined: a granted request with address 0 SHALL skip READ, go directly to RESP with RSP_DATA=0, and leave S unchanged.
REQ-029 Macro RF_ARB_ZERO_REG_EN undefined: address 0 SHALL be handled like any other address, through READ, returning Y.

Structure
REQ-030 Package rf_arb_pkg SHALL hold the state enum (IDLE/READ/RESP) and the default AW/DW constants.
REQ-031 Round-robin selection SHALL be a sub-module rr_arbiter (inputs: request vector, PTR; outputs: one-hot grant, winner index).

Verification
The bench models the mux as Y = S*32'h11.
REQ-032 Single request: REQ_VALID[2]=1, addr 7 -> REQ_READY[2] in cycle 0; RSP_VALID in cycle 2; RSP_ID=2; RSP_DATA=0x77.
REQ-033 All 4 requesters valid continuously, RSP_READY=1, PTR=0 -> grant order 0,1,2,3,0; one response every 2 cycles.
REQ-034 Backpressure: RSP_READY=0 for 5 cycles in RESP -> RSP_DATA/RSP_ID stable, no REQ_READY; release -> next grant in the same cycle.
REQ-035 PTR wrap: last grant was to requester 3, requesters 0 and 3 both valid -> requester 0 wins.
REQ-036 Rst pulsed during READ -> RSP_VALID stays 0, state IDLE, PTR=0; a fresh request completes normally.
REQ-037 Address 0 with RF_ARB_ZERO_REG_EN defined -> RSP_VALID in cycle 1, RSP_DATA=0; undefined -> cycle 2, RSP_DATA=0 (from Y).
